conv_seq_ctrl: RTL and testbench
================================

CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

Interface
REQ-001 Parameter F_MEM_SIZE, default 4, filter words per frame.
REQ-002 Parameter X_MEM_SIZE, default 8, input vector words per frame; SHALL be greater than F_MEM_SIZE.
REQ-003 Parameter X_MEM_ADDR_WIDTH, default 3, x memory address width.
REQ-004 Parameter F_MEM_ADDR_WIDTH, default 2, f memory address width.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 en  in  1  level; permits leaving IDLE.
REQ-008 f_keep  in  1  sampled on LOAD entry; reuse the previously loaded filter.
REQ-009 s_valid_f  in  1  / s_ready_f  out  1  filter stream handshake.
REQ-010 s_valid_x  in  1  / s_ready_x  out  1  input stream handshake.
REQ-011 wr_en_f  out  1, wr_addr_f  out  F_MEM_ADDR_WIDTH  filter memory write port.
REQ-012 wr_en_x  out  1, wr_addr_x  out  X_MEM_ADDR_WIDTH  x memory write port.
REQ-013 conv_start  out  1  level; enables the convolution output controller.
REQ-014 conv_done  in  1  one-cycle pulse from the convolution output controller.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 frame_cnt  out  8  completed frames, wraps 255->0.

Function
REQ-017 FSM states: IDLE, LOAD, CONV, FLUSH; state register only.
REQ-018 IDLE->LOAD when en=1; LOAD->CONV when f_full and x_full; CONV->FLUSH on conv_done=1; FLUSH->LOAD when en=1, else FLUSH->IDLE, after exactly one cycle.
REQ-019 On each LOAD entry, x_cnt is cleared to 0; f_cnt is cleared to 0 unless f_keep=1 and f_loaded=1, in which case f_full is set immediately.
REQ-020 s_ready_f = (state==LOAD) and not f_full; s_ready_x = (state==LOAD) and not x_full; both are combinational from registers, with no dependence on s_valid.
REQ-021 wr_en_f = s_valid_f and s_ready_f; wr_addr_f = f_cnt. The same rule applies to x.
REQ-022 Each accepted word increments its counter. f_full sets on acceptance of word F_MEM_SIZE-1, and x_full on word X_MEM_SIZE-1. Counters never exceed size-1.
REQ-023 The f and x streams load concurrently and independently. Last-f and last-x accepted in the same cycle gives CONV on the next cycle.
REQ-024 conv_start is registered: it is 1 exactly while state==CONV and 0 in all other states, including FLUSH, which guarantees one cycle low between frames.
REQ-025 conv_done is ignored outside CONV.
REQ-026 f_loaded sets when f_full is first reached by loading, and clears only on reset.
REQ-027 frame_cnt increments on the CONV->FLUSH transition.
REQ-028 f_keep=1 with f_loaded=0 loads the filter normally.
REQ-029 en deasserted during LOAD or CONV does not abort the frame; it only gates the IDLE and FLUSH exits.

Reset
REQ-030 While reset=1, the block SHALL hold state=IDLE; f_cnt=x_cnt=0; f_full=x_full=f_loaded=0; conv_start=0; frame_cnt=0; all ready and write-enable outputs 0.
REQ-031 Reset asserted mid-LOAD or mid-CONV takes priority over every other condition, and the partially loaded filter is discarded (f_loaded=0).

Structure
REQ-032 Package conv_pkg SHALL hold the state enum (IDLE, LOAD, CONV, FLUSH) and the frame counter width constant (8).
REQ-033 Sub-module load_counter (parameters SIZE, WIDTH; inputs clear, inc; outputs cnt, full) SHALL be instantiated once per stream.
REQ-034 conv_start SHALL connect directly to the conv_start input of the convolution output controller, and its conv_done SHALL connect back to this block.

Verification
REQ-035 Defaults; en=1; 4 f words and 8 x words with valid always high -> wr_addr_f 0..3, wr_addr_x 0..7, conv_start=1 on the cycle after the 8th x accept.
REQ-036 x stream complete first, then f valid toggling 1,0,1,0 -> s_ready_x=0 after 8 words, with no x write while waiting. Entry to CONV occurs one cycle after the 4th f accept.
REQ-037 conv_done pulse in CONV with en=1 -> conv_start 0 for exactly 1 cycle (FLUSH), state LOAD, x_cnt=0, frame_cnt=1.
REQ-038 Second frame with f_keep=1 -> s_ready_f=0 throughout LOAD, no wr_en_f, CONV after 8 x words.
REQ-039 Reset asserted after 2 x words in LOAD -> next cycle IDLE, all outputs 0. A later f_keep=1 frame still loads 4 f words.
REQ-040 conv_done pulses during LOAD and IDLE -> no state change, frame_cnt unchanged.

Source files
------------

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and constants for the convolution sequencer
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CONV  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam int FRAME_CNT_WIDTH = 8;

endpackage

// File: rtl/load_counter.sv
// rtl/load_counter.sv - per-stream word counter that saturates at SIZE-1 and flags full
module load_counter #(
  parameter int SIZE  = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             set_full,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt,
  output logic             full
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(SIZE - 1);

  // The final word is written at LAST; full is raised instead of advancing past it.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt  <= '0;
      full <= 1'b0;
    end else if (set_full) begin
      full <= 1'b1;
    end else if (inc && !full) begin
      if (cnt == LAST) begin
        full <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv_seq_ctrl.sv
// rtl/conv_seq_ctrl.sv - frame sequencer: loads filter/input memories, then hands off to convolution
module conv_seq_ctrl
  import conv_pkg::*;
#(
  parameter int F_MEM_SIZE       = 4,
  parameter int X_MEM_SIZE       = 8,
  parameter int X_MEM_ADDR_WIDTH = 3,
  parameter int F_MEM_ADDR_WIDTH = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic                        f_keep,
  input  logic                        s_valid_f,
  output logic                        s_ready_f,
  input  logic                        s_valid_x,
  output logic                        s_ready_x,
  output logic                        wr_en_f,
  output logic [F_MEM_ADDR_WIDTH-1:0] wr_addr_f,
  output logic                        wr_en_x,
  output logic [X_MEM_ADDR_WIDTH-1:0] wr_addr_x,
  output logic                        conv_start,
  input  logic                        conv_done,
  output logic                        busy,
  output logic [FRAME_CNT_WIDTH-1:0]  frame_cnt
);

  localparam logic [F_MEM_ADDR_WIDTH-1:0] F_LAST = F_MEM_ADDR_WIDTH'(F_MEM_SIZE - 1);
  localparam logic [X_MEM_ADDR_WIDTH-1:0] X_LAST = X_MEM_ADDR_WIDTH'(X_MEM_SIZE - 1);

  state_t state, next_state;

  logic                        f_full, x_full, f_loaded;
  logic [F_MEM_ADDR_WIDTH-1:0] f_cnt;
  logic [X_MEM_ADDR_WIDTH-1:0] x_cnt;
  logic                        load_entry, keep_f, f_last_acc, x_last_acc;

  assign load_entry = (next_state == LOAD) && (state != LOAD);
  assign keep_f     = f_keep && f_loaded;

  assign s_ready_f  = (state == LOAD) && !f_full;
  assign s_ready_x  = (state == LOAD) && !x_full;
  assign wr_en_f    = s_valid_f && s_ready_f;
  assign wr_en_x    = s_valid_x && s_ready_x;
  assign wr_addr_f  = f_cnt;
  assign wr_addr_x  = x_cnt;
  assign busy       = (state != IDLE);

  // Looking at the accepting word lets CONV begin the cycle right after the final accept.
  assign f_last_acc = wr_en_f && (f_cnt == F_LAST);
  assign x_last_acc = wr_en_x && (x_cnt == X_LAST);

  load_counter #(
    .SIZE  (F_MEM_SIZE),
    .WIDTH (F_MEM_ADDR_WIDTH)
  ) u_f_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (load_entry && !keep_f),
    .set_full (load_entry && keep_f),
    .inc      (wr_en_f),
    .cnt      (f_cnt),
    .full     (f_full)
  );

  load_counter #(
    .SIZE  (X_MEM_SIZE),
    .WIDTH (X_MEM_ADDR_WIDTH)
  ) u_x_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (load_entry),
    .set_full (1'b0),
    .inc      (wr_en_x),
    .cnt      (x_cnt),
    .full     (x_full)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (en) next_state = LOAD;
      LOAD:    if ((f_full || f_last_acc) && (x_full || x_last_acc)) next_state = CONV;
      CONV:    if (conv_done) next_state = FLUSH;
      FLUSH:   next_state = en ? LOAD : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      conv_start <= 1'b0;
      frame_cnt  <= '0;
      f_loaded   <= 1'b0;
    end else begin
      state      <= next_state;
      conv_start <= (next_state == CONV);
      if (state == CONV && conv_done) frame_cnt <= frame_cnt + 1'b1;
      if (f_last_acc) f_loaded <= 1'b1;
    end
  end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb/tb_conv_seq_ctrl.sv - self-checking bench for conv_seq_ctrl against a word-count model
module tb_conv_seq_ctrl;

  localparam int F = 4;
  localparam int X = 8;

  logic       clk = 1'b0;
  logic       reset, en, f_keep, s_valid_f, s_valid_x, conv_done;
  logic       s_ready_f, s_ready_x, wr_en_f, wr_en_x, conv_start, busy;
  logic [1:0] wr_addr_f;
  logic [2:0] wr_addr_x;
  logic [7:0] frame_cnt;

  int checks   = 0;
  int failures = 0;
  int frames   = 0;

  conv_seq_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .f_keep     (f_keep),
    .s_valid_f  (s_valid_f),
    .s_ready_f  (s_ready_f),
    .s_valid_x  (s_valid_x),
    .s_ready_x  (s_ready_x),
    .wr_en_f    (wr_en_f),
    .wr_addr_f  (wr_addr_f),
    .wr_en_x    (wr_en_x),
    .wr_addr_x  (wr_addr_x),
    .conv_start (conv_start),
    .conv_done  (conv_done),
    .busy       (busy),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_rdy_f"}, 32'(s_ready_f), 0);
    check({tag, "_rdy_x"}, 32'(s_ready_x), 0);
    check({tag, "_wen_f"}, 32'(wr_en_f), 0);
    check({tag, "_wen_x"}, 32'(wr_en_x), 0);
    check({tag, "_cstart"}, 32'(conv_start), 0);
    check({tag, "_frames"}, 32'(frame_cnt), 32'(frames % 256));
  endtask

  // Entered at a negedge with the DUT in its first LOAD cycle; returns in the first CONV cycle.
  // pat 0: both valids high; 1: random valids plus stray conv_done; 2: x first, then f toggling.
  task automatic load_frame(input int pat, input bit kept);
    int nf, nx, cyc;
    bit vf, vx, tog;
    nf = kept ? F : 0;
    nx = 0;
    cyc = 0;
    tog = 1'b1;
    while (!(nf == F && nx == X) && cyc < 200) begin
      case (pat)
        0: begin vf = 1'b1; vx = 1'b1; end
        1: begin vf = 1'($urandom_range(0, 1)); vx = 1'($urandom_range(0, 1)); end
        default: begin
          vx = 1'b1;
          if (nx < X) vf = 1'b0;
          else begin vf = tog; tog = !tog; end
        end
      endcase
      s_valid_f = vf;
      s_valid_x = vx;
      conv_done = (pat == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
      #1;
      check("load_rdy_f", 32'(s_ready_f), 32'(nf < F));
      check("load_rdy_x", 32'(s_ready_x), 32'(nx < X));
      check("load_wen_f", 32'(wr_en_f), 32'(vf && nf < F));
      check("load_wen_x", 32'(wr_en_x), 32'(vx && nx < X));
      check("load_addr_f", 32'(wr_addr_f), 32'((nf < F) ? nf : F - 1));
      check("load_addr_x", 32'(wr_addr_x), 32'((nx < X) ? nx : X - 1));
      check("load_cstart", 32'(conv_start), 0);
      check("load_busy", 32'(busy), 1);
      check("load_frames", 32'(frame_cnt), 32'(frames % 256));
      if (vf && nf < F) nf++;
      if (vx && nx < X) nx++;
      cyc++;
      @(negedge clk);
    end
    check("load_budget", 32'(cyc < 200), 1);
    s_valid_f = 1'b0;
    s_valid_x = 1'b0;
    conv_done = 1'b0;
    #1;
    check("conv_cstart", 32'(conv_start), 1);
    check("conv_busy", 32'(busy), 1);
    check("conv_rdy_f", 32'(s_ready_f), 0);
    check("conv_rdy_x", 32'(s_ready_x), 0);
  endtask

  // Holds CONV with en low, then pulses conv_done and checks the single FLUSH cycle.
  task automatic run_conv(input int hold, input bit en_next, input bit keep_next);
    en = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      #1;
      check("hold_cstart", 32'(conv_start), 1);
      check("hold_busy", 32'(busy), 1);
    end
    @(negedge clk);
    conv_done = 1'b1;
    en = en_next;
    f_keep = keep_next;
    #1;
    check("done_cstart", 32'(conv_start), 1);
    frames++;
    @(negedge clk);
    conv_done = 1'b0;
    #1;
    check("flush_cstart", 32'(conv_start), 0);
    check("flush_busy", 32'(busy), 1);
    check("flush_frames", 32'(frame_cnt), 32'(frames % 256));
    check("flush_rdy_x", 32'(s_ready_x), 0);
    @(negedge clk);
    if (!en_next) begin
      #1;
      check_quiet("idle");
    end
  endtask

  initial begin
    reset = 1'b1;
    en = 1'b0;
    f_keep = 1'b0;
    s_valid_f = 1'b0;
    s_valid_x = 1'b0;
    conv_done = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_quiet("reset");
    check("reset_addr_f", 32'(wr_addr_f), 0);
    check("reset_addr_x", 32'(wr_addr_x), 0);

    reset = 1'b0;
    en = 1'b1;
    @(negedge clk);
    load_frame(0, 1'b0);
    run_conv(3, 1'b1, 1'b0);

    load_frame(2, 1'b0);
    run_conv(2, 1'b1, 1'b1);

    load_frame(1, 1'b1);
    run_conv(1, 1'b0, 1'b0);

    repeat (4) begin
      @(negedge clk);
      conv_done = 1'($urandom_range(0, 1));
      #1;
      check_quiet("idle_done");
    end
    conv_done = 1'b0;

    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    s_valid_x = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("part_wen_x", 32'(wr_en_x), 1);
      check("part_addr_x", 32'(wr_addr_x), 32'(i));
      @(negedge clk);
    end
    reset = 1'b1;
    s_valid_x = 1'b0;
    frames = 0;
    @(negedge clk);
    #1;
    check_quiet("midreset");
    check("midreset_addr_x", 32'(wr_addr_x), 0);
    reset = 1'b0;
    en = 1'b1;
    f_keep = 1'b1;
    @(negedge clk);
    load_frame(1, 1'b0);
    run_conv(2, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
